vga_timing_gen: RTL and testbench

Parametrised VGA timing generator for the display path of the space shooter. Runs from the single system clock and derives a pixel clock-enable plus a VGA_CLK pin from it. It issues pixel request coordinates REQ_LEAD pixel periods ahead of the pins, so a pipelined renderer's R/G/B returns in time for its pixel. Sync, blank and colour leave through one aligned registered stage. Timing, sync polarity, divider and colour width are all configurable.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_delay_line.sv | 35 +++
 rtl/vga_timing_gen.sv | 182 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA timing generator: default
// 640x480@60 timing, sync polarity names and timing arithmetic.
package vga_pkg;

  // Default 640x480@60 horizontal timing (pixel periods)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Default 640x480@60 vertical timing (lines)
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Asserted level of a sync pin
  localparam bit POL_LOW  = 1'b0;
  localparam bit POL_HIGH = 1'b1;

  // Full period of one axis: active + porches + sync
  function automatic int vga_total(input int active, input int fp,
                                   input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // First counter value at which sync is asserted
  function automatic int vga_sync_start(input int active, input int fp);
    return active + fp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enable gated shift register with synchronous reset to RST_VAL.
// DEPTH = 0 degenerates to a straight wire so callers can ask for "no delay".
module vga_delay_line #(
  parameter int                WIDTH   = 3,
  parameter int                DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, i_ce};
    assign o_q      = i_d;
  end else begin : g_shift
    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift one stage per enabled clock; reset clears every stage
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
      end else if (i_ce) begin
        r_stage[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel clock-enable from the system clock, raster
// counters, request coordinates issued REQ_LEAD pixels ahead, and one aligned
// registered output stage for sync, blank and colour.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = POL_LOW,
  parameter bit VS_POL   = POL_LOW,
  parameter int CLK_DIV  = 2,
  parameter int REQ_LEAD = 2,
  parameter int CW       = 8,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CW-1:0]    R,
  input  logic [CW-1:0]    G,
  input  logic [CW-1:0]    B,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             req_valid,
  output logic             pix_ce,
  output logic             new_line,
  output logic             new_frame,
  output logic             VGA_CLK,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_N,
  output logic             VGA_SYNC_N,
  output logic [CW-1:0]    VGA_R,
  output logic [CW-1:0]    VGA_G,
  output logic [CW-1:0]    VGA_B
);

  localparam int H_TOTAL  = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = vga_sync_start(H_ACTIVE, H_FP);
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = vga_sync_start(V_ACTIVE, V_FP);
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV <= 2) ? 1 : $clog2(CLK_DIV);
  // One extra bit so decode constants equal to 2^CNT_W still compare correctly
  localparam int CW1      = CNT_W + 1;

  if (CLK_DIV < 2) begin : g_err_div
    $error("vga_timing_gen: CLK_DIV must be 2 or more");
  end
  if (REQ_LEAD < 1 || REQ_LEAD > 8) begin : g_err_lead
    $error("vga_timing_gen: REQ_LEAD must be within 1..8");
  end
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_err_cnt
    $error("vga_timing_gen: timing totals exceed the counter range");
  end

  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_next;
  logic             w_tick;
  logic [CNT_W-1:0] r_hc, r_vc;
  logic [CNT_W-1:0] w_hc_next, w_vc_next;
  logic [CW1-1:0]   w_hc_ext, w_vc_ext;
  logic             w_hs_a, w_vs_a, w_vis;
  logic [2:0]       w_late;
  logic             r_pix_ce, r_new_line, r_new_frame, r_vga_clk;
  logic             r_vga_hs, r_vga_vs, r_blank_n, r_sync_n;
  logic [CW-1:0]    r_vga_r, r_vga_g, r_vga_b;

  // Divider and raster counter next-state; en = 0 leaves everything as is
  always_comb begin
    w_tick     = en && (r_div_cnt == DIV_W'(CLK_DIV - 1));
    w_div_next = r_div_cnt;
    w_hc_next  = r_hc;
    w_vc_next  = r_vc;
    if (en) begin
      w_div_next = w_tick ? '0 : r_div_cnt + DIV_W'(1);
    end
    if (w_tick) begin
      if (r_hc == CNT_W'(H_TOTAL - 1)) begin
        w_hc_next = '0;
        w_vc_next = (r_vc == CNT_W'(V_TOTAL - 1)) ? '0 : r_vc + CNT_W'(1);
      end else begin
        w_hc_next = r_hc + CNT_W'(1);
      end
    end
  end

  // Divider, pixel clock pin and one-cycle strobes, all aligned to the counter update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt   <= '0;
      r_vga_clk   <= 1'b0;
      r_pix_ce    <= 1'b0;
      r_new_line  <= 1'b0;
      r_new_frame <= 1'b0;
    end else begin
      r_div_cnt   <= w_div_next;
      r_vga_clk   <= (w_div_next >= DIV_W'(CLK_DIV / 2));
      r_pix_ce    <= w_tick;
      r_new_line  <= w_tick && (w_hc_next == '0);
      r_new_frame <= w_tick && (w_hc_next == '0) &&
                     ({1'b0, w_vc_next} == CW1'(V_ACTIVE));
    end
  end

  // Horizontal and vertical raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hc <= '0;
      r_vc <= '0;
    end else begin
      r_hc <= w_hc_next;
      r_vc <= w_vc_next;
    end
  end

  // Decode of the request position
  always_comb begin
    w_hc_ext = {1'b0, r_hc};
    w_vc_ext = {1'b0, r_vc};
    w_vis    = (w_hc_ext < CW1'(H_ACTIVE)) && (w_vc_ext < CW1'(V_ACTIVE));
    w_hs_a   = (w_hc_ext >= CW1'(HS_START)) && (w_hc_ext < CW1'(HS_END));
    w_vs_a   = (w_vc_ext >= CW1'(VS_START)) && (w_vc_ext < CW1'(VS_END));
  end

  // The pin register below is the last of the REQ_LEAD stages
  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (REQ_LEAD - 1),
    .RST_VAL (3'b000)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .i_ce (w_tick),
    .i_d  ({w_hs_a, w_vs_a, w_vis}),
    .o_q  (w_late)
  );

  // Output pin stage: sync at configured polarity, blank and gated colour
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vga_hs  <= ~HS_POL;
      r_vga_vs  <= ~VS_POL;
      r_blank_n <= 1'b0;
      r_sync_n  <= 1'b1;
      r_vga_r   <= '0;
      r_vga_g   <= '0;
      r_vga_b   <= '0;
    end else if (w_tick) begin
      r_vga_hs  <= w_late[2] ^ ~HS_POL;
      r_vga_vs  <= w_late[1] ^ ~VS_POL;
      r_blank_n <= w_late[0];
      r_sync_n  <= ~(w_late[2] | w_late[1]);
      r_vga_r   <= w_late[0] ? R : '0;
      r_vga_g   <= w_late[0] ? G : '0;
      r_vga_b   <= w_late[0] ? B : '0;
    end
  end

  assign x           = r_hc;
  assign y           = r_vc;
  assign req_valid   = w_vis;
  assign pix_ce      = r_pix_ce;
  assign new_line    = r_new_line;
  assign new_frame   = r_new_frame;
  assign VGA_CLK     = r_vga_clk;
  assign VGA_HS      = r_vga_hs;
  assign VGA_VS      = r_vga_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_SYNC_N  = r_sync_n;
  assign VGA_R       = r_vga_r;
  assign VGA_G       = r_vga_g;
  assign VGA_B       = r_vga_b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (default horizontal timing with a
// short frame, and a tiny CLK_DIV=4 active-high-sync raster) driven with
// random en/rst/colour and compared each cycle against an arithmetic model.
module tb_vga_timing_gen;

  localparam int NCYC = 30000;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, div, lead;
    bit hpol, vpol;
  } cfg_t;

  logic       clk;
  logic       rst_i  [2];
  logic       en_i   [2];
  logic [7:0] r_i    [2];
  logic [7:0] g_i    [2];
  logic [7:0] b_i    [2];
  logic [9:0] x_o    [2];
  logic [9:0] y_o    [2];
  logic       rv_o   [2];
  logic       pce_o  [2];
  logic       nl_o   [2];
  logic       nf_o   [2];
  logic       vclk_o [2];
  logic       hs_o   [2];
  logic       vs_o   [2];
  logic       bn_o   [2];
  logic       sn_o   [2];
  logic [7:0] vr_o   [2];
  logic [7:0] vg_o   [2];
  logic [7:0] vb_o   [2];

  cfg_t       cfg [2];
  string      nm  [2];
  int         e_cnt [2];
  bit         tick  [2];
  logic [7:0] er [2], eg [2], eb [2];

  int n_vec = 0;
  int n_bad = 0;

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .REQ_LEAD(2), .CW(8), .CNT_W(10)
  ) u_dut_a (
    .clk(clk), .rst(rst_i[0]), .en(en_i[0]),
    .R(r_i[0]), .G(g_i[0]), .B(b_i[0]),
    .x(x_o[0]), .y(y_o[0]), .req_valid(rv_o[0]), .pix_ce(pce_o[0]),
    .new_line(nl_o[0]), .new_frame(nf_o[0]), .VGA_CLK(vclk_o[0]),
    .VGA_HS(hs_o[0]), .VGA_VS(vs_o[0]), .VGA_BLANK_N(bn_o[0]), .VGA_SYNC_N(sn_o[0]),
    .VGA_R(vr_o[0]), .VGA_G(vg_o[0]), .VGA_B(vb_o[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(4), .REQ_LEAD(1), .CW(8), .CNT_W(10)
  ) u_dut_b (
    .clk(clk), .rst(rst_i[1]), .en(en_i[1]),
    .R(r_i[1]), .G(g_i[1]), .B(b_i[1]),
    .x(x_o[1]), .y(y_o[1]), .req_valid(rv_o[1]), .pix_ce(pce_o[1]),
    .new_line(nl_o[1]), .new_frame(nf_o[1]), .VGA_CLK(vclk_o[1]),
    .VGA_HS(hs_o[1]), .VGA_VS(vs_o[1]), .VGA_BLANK_N(bn_o[1]), .VGA_SYNC_N(sn_o[1]),
    .VGA_R(vr_o[1]), .VGA_G(vg_o[1]), .VGA_B(vb_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int htot(input cfg_t c);
    return c.ha + c.hfp + c.hs + c.hbp;
  endfunction

  function automatic int vtot(input cfg_t c);
    return c.va + c.vfp + c.vs + c.vbp;
  endfunction

  // Raster position reached after t pixel periods since reset
  task automatic pos_of(input cfg_t c, input int t, output int h, output int v);
    h = t % htot(c);
    v = (t / htot(c)) % vtot(c);
  endtask

  // What the pins show after t pixel periods: the decode of pixel t - lead
  task automatic pin_decode(input cfg_t c, input int t, output bit hsa, output bit vsa, output bit vis);
    int ph, pv;
    hsa = 1'b0; vsa = 1'b0; vis = 1'b0;
    if (t >= c.lead) begin
      pos_of(c, t - c.lead, ph, pv);
      hsa = (ph >= c.ha + c.hfp) && (ph < c.ha + c.hfp + c.hs);
      vsa = (pv >= c.va + c.vfp) && (pv < c.va + c.vfp + c.vs);
      vis = (ph < c.ha) && (pv < c.va);
    end
  endtask

  // Advance the model by one clock edge using the inputs applied at that edge
  task automatic model_edge(input int i);
    bit hsa, vsa, vis;
    if (rst_i[i]) begin
      e_cnt[i] = 0; tick[i] = 1'b0;
      er[i] = 8'd0; eg[i] = 8'd0; eb[i] = 8'd0;
    end else if (en_i[i]) begin
      e_cnt[i]++;
      tick[i] = (e_cnt[i] % cfg[i].div) == 0;
      if (tick[i]) begin
        pin_decode(cfg[i], e_cnt[i] / cfg[i].div, hsa, vsa, vis);
        er[i] = vis ? r_i[i] : 8'd0;
        eg[i] = vis ? g_i[i] : 8'd0;
        eb[i] = vis ? b_i[i] : 8'd0;
      end
    end else begin
      tick[i] = 1'b0;
    end
  endtask

  task automatic check_inst(input int i);
    int t, hc, vc;
    bit hsa, vsa, vis;
    t = e_cnt[i] / cfg[i].div;
    pos_of(cfg[i], t, hc, vc);
    pin_decode(cfg[i], t, hsa, vsa, vis);
    chk({nm[i], ".x"}, 32'(x_o[i]), hc);
    chk({nm[i], ".y"}, 32'(y_o[i]), vc);
    chk({nm[i], ".req_valid"}, 32'(rv_o[i]), 32'((hc < cfg[i].ha) && (vc < cfg[i].va)));
    chk({nm[i], ".pix_ce"}, 32'(pce_o[i]), 32'(tick[i]));
    chk({nm[i], ".new_line"}, 32'(nl_o[i]), 32'(tick[i] && hc == 0));
    chk({nm[i], ".new_frame"}, 32'(nf_o[i]), 32'(tick[i] && hc == 0 && vc == cfg[i].va));
    chk({nm[i], ".vga_clk"}, 32'(vclk_o[i]), 32'((e_cnt[i] % cfg[i].div) >= cfg[i].div / 2));
    chk({nm[i], ".hs"}, 32'(hs_o[i]), 32'(hsa ? cfg[i].hpol : !cfg[i].hpol));
    chk({nm[i], ".vs"}, 32'(vs_o[i]), 32'(vsa ? cfg[i].vpol : !cfg[i].vpol));
    chk({nm[i], ".blank_n"}, 32'(bn_o[i]), 32'(vis));
    chk({nm[i], ".sync_n"}, 32'(sn_o[i]), 32'(!(hsa || vsa)));
    chk({nm[i], ".r"}, 32'(vr_o[i]), 32'(er[i]));
    chk({nm[i], ".g"}, 32'(vg_o[i]), 32'(eg[i]));
    chk({nm[i], ".b"}, 32'(vb_o[i]), 32'(eb[i]));
  endtask

  // Renderer: R is the low byte of the x being displayed by the next pixel update
  task automatic drive_colour(input int i);
    int tn, h, v;
    tn = e_cnt[i] / cfg[i].div + 1 - cfg[i].lead;
    if (tn >= 0) begin
      pos_of(cfg[i], tn, h, v);
      r_i[i] = 8'(h);
    end else begin
      r_i[i] = 8'($urandom);
    end
    g_i[i] = 8'($urandom);
    b_i[i] = 8'($urandom);
  endtask

  // Direct measurements on instance A, independent of the position model
  int line_len, frame_len, hs_run;
  bit line_ok, frame_ok, hs_ok;

  task automatic track_a(input bit was_rst);
    if (was_rst) begin
      line_ok = 1'b0; frame_ok = 1'b0; hs_ok = 1'b0; hs_run = 0;
    end else if (pce_o[0]) begin
      line_len++; frame_len++;
      if (nl_o[0]) begin
        if (line_ok) chk("A.line_len", line_len, 800);
        line_ok = 1'b1; line_len = 0;
      end
      if (nf_o[0]) begin
        if (frame_ok) chk("A.frame_len", frame_len, 6400);
        frame_ok = 1'b1; frame_len = 0;
      end
      if (hs_o[0] == 1'b0) begin
        hs_run++;
      end else begin
        if (hs_ok && hs_run > 0) chk("A.hs_width", hs_run, 96);
        hs_ok = 1'b1; hs_run = 0;
      end
      if (bn_o[0] == 1'b0) chk("A.r_blanked", 32'(vr_o[0]), 0);
    end
  endtask

  initial begin
    bit did_rst;
    bit rst_prev0;
    int hc0, vc0;
    cfg[0] = '{ha:640, hfp:16, hs:96, hbp:48, va:4, vfp:1, vs:1, vbp:2, div:2, lead:2, hpol:1'b0, vpol:1'b0};
    cfg[1] = '{ha:8,   hfp:2,  hs:2,  hbp:2,  va:4, vfp:1, vs:1, vbp:1, div:4, lead:1, hpol:1'b1, vpol:1'b1};
    nm[0] = "A";
    nm[1] = "B";
    did_rst = 1'b0;
    line_ok = 1'b0; frame_ok = 1'b0; hs_ok = 1'b0;
    line_len = 0; frame_len = 0; hs_run = 0;
    for (int i = 0; i < 2; i++) begin
      e_cnt[i] = 0; tick[i] = 1'b0;
      er[i] = 8'd0; eg[i] = 8'd0; eb[i] = 8'd0;
    end

    for (int c = 0; c < NCYC; c++) begin
      // Inputs for the coming edge
      pos_of(cfg[0], e_cnt[0] / cfg[0].div, hc0, vc0);
      if (c < 3) begin
        rst_i[0] = 1'b1;
      end else if (!did_rst && c > 22000 && hc0 == 300 && vc0 < cfg[0].va) begin
        rst_i[0] = 1'b1;
        did_rst  = 1'b1;
      end else begin
        rst_i[0] = 1'b0;
      end
      en_i[0]  = !(c >= 5000 && c < 5050) && ($urandom_range(0, 31) != 0);
      rst_i[1] = (c < 3) || ($urandom_range(0, 2999) == 0);
      en_i[1]  = !(c >= 8000 && c < 8050) && ($urandom_range(0, 15) != 0);
      drive_colour(0);
      drive_colour(1);

      @(posedge clk);
      rst_prev0 = rst_i[0];
      model_edge(0);
      model_edge(1);

      @(negedge clk);
      check_inst(0);
      check_inst(1);
      track_a(rst_prev0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
